// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA request-side front end.
package dma_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  // Bit positions within the 8-bit command register.
  localparam int unsigned CMD_DISABLE   = 2;
  localparam int unsigned CMD_ROTATE    = 4;
  localparam int unsigned CMD_DREQ_LOW  = 6;
  localparam int unsigned CMD_DACK_HIGH = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    SERVICE = 2'd2,
    DONE    = 2'd3
  } state_e;

  function automatic logic [NUM_CH-1:0] onehot4(input logic [CH_W-1:0] idx);
    onehot4 = NUM_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Combinational channel arbiter: fixed (ch0 highest) or rotating from a pointer.
module dma_rr_arbiter
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] act,
  input  logic [CH_W-1:0]   pointer,
  input  logic              rotating,
  output logic [CH_W-1:0]   winner,
  output logic              any
);

  logic [CH_W-1:0] base;
  logic [CH_W-1:0] idx;

  // Scan from the lowest priority upward so the highest-priority hit wins last.
  always_comb begin
    base   = rotating ? pointer : '0;
    idx    = '0;
    winner = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = base + CH_W'(i);
      if (act[idx]) winner = idx;
    end
    any = |act;
  end

endmodule

// File: rtl/dma_priority_resolver.sv
// DREQ synchronisation, request merging, arbitration and DACK generation
// feeding the DMA timing-control FSM.
module dma_priority_resolver
  import dma_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  output logic [NUM_CH-1:0] DACK,
  input  logic [NUM_CH-1:0] mask,
  input  logic [NUM_CH-1:0] sw_req,
  input  logic              cmd_disable,
  input  logic              cmd_rotating,
  input  logic              cmd_dreq_low,
  input  logic              cmd_dack_high,
  input  logic              valid_dack,
  input  logic              hlda,
  input  logic              svc_end,
  output logic [NUM_CH-1:0] valid_dreq,
  output logic [CH_W-1:0]   sel_ch,
  output logic [NUM_CH-1:0] sw_req_clr,
  output logic [NUM_CH-1:0] status_req
);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] dreq_sync;
  logic [NUM_CH-1:0] act;

  state_e            state_q, state_n;
  logic [CH_W-1:0]   sel_q, sel_n;
  logic [CH_W-1:0]   ptr_q, ptr_n;
  logic [NUM_CH-1:0] vdreq_q, vdreq_n;
  logic [NUM_CH-1:0] dack_q, dack_n;
  logic [NUM_CH-1:0] clr_q, clr_n;
  logic [NUM_CH-1:0] status_q;

  logic [CH_W-1:0]   winner;
  logic              any;

  // Metastability synchroniser; deliberately left without reset.
  always_ff @(posedge CLK) begin
    sync_q[0] <= DREQ;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_q[i] <= sync_q[i-1];
    end
  end

  assign dreq_sync = sync_q[SYNC_STAGES-1];
  assign act       = ((dreq_sync ^ {NUM_CH{cmd_dreq_low}}) & ~mask) | sw_req;

  dma_rr_arbiter u_arb (
    .act      (act),
    .pointer  (ptr_q),
    .rotating (cmd_rotating),
    .winner   (winner),
    .any      (any)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      ptr_q    <= '0;
      vdreq_q  <= '0;
      dack_q   <= '0;
      clr_q    <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_n;
      sel_q    <= sel_n;
      ptr_q    <= ptr_n;
      vdreq_q  <= vdreq_n;
      dack_q   <= dack_n;
      clr_q    <= clr_n;
      status_q <= act;
    end
  end

  // Next-state and next-output logic; sw_req_clr is staged so it is high during DONE.
  always_comb begin
    state_n = state_q;
    sel_n   = sel_q;
    ptr_n   = ptr_q;
    vdreq_n = vdreq_q;
    dack_n  = dack_q;
    clr_n   = '0;
    unique case (state_q)
      IDLE: begin
        vdreq_n = '0;
        if (any && !cmd_disable) begin
          sel_n   = winner;
          vdreq_n = onehot4(winner);
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (cmd_disable || !act[sel_q]) begin
          vdreq_n = '0;
          state_n = IDLE;
        end else if (valid_dack) begin
          dack_n  = onehot4(sel_q);
          state_n = SERVICE;
        end
      end
      SERVICE: begin
        if (svc_end || !hlda) begin
          dack_n  = '0;
          vdreq_n = '0;
          clr_n   = sw_req[sel_q] ? onehot4(sel_q) : '0;
          state_n = DONE;
        end
      end
      DONE: begin
        if (cmd_rotating) ptr_n = sel_q + 2'd1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign DACK       = cmd_dack_high ? dack_q : ~dack_q;
  assign valid_dreq = vdreq_q;
  assign sel_ch     = sel_q;
  assign sw_req_clr = clr_q;
  assign status_req = status_q;

endmodule
